// File: rtl/mult2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult2_seq_ctrl
//
// Sequencing controller for a WIDTH x WIDTH unsigned multiply built from one
// shared, external, combinational 2-bit x 2-bit multiplier. Both operands are
// split into N = WIDTH/2 two-bit digits. One digit pair is presented to the
// multiplier per cycle (i = A digit, outer loop; j = B digit, inner loop), and
// the shifted 4-bit partial products are summed into a 2*WIDTH accumulator.
// Latency is fixed at N*N cycles; zero digits do not shorten it.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   multiply request, sampled only while idle
//   a_in     in   [WIDTH-1:0]   multiplicand, captured on accept
//   b_in     in   [WIDTH-1:0]   multiplier, captured on accept
//   mul_a    out  [1:0]         A digit to the shared 2x2 multiplier
//   mul_b    out  [1:0]         B digit to the shared 2x2 multiplier
//   mul_p    in   [3:0]         combinational product from the 2x2 multiplier
//   busy     out  operation in progress
//   done     out  one-cycle pulse when product is updated
//   product  out  [2*WIDTH-1:0] result, held until the next completion
// ---------------------------------------------------------------------------
module mult2_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [1:0]           mul_a,
    output logic [1:0]           mul_b,
    input  logic [3:0]           mul_p,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1
    } state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [IW-1:0]        i_reg;
    logic [IW-1:0]        j_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   product_reg;

    // Digit views of the captured operands.
    logic [1:0] a_dig [N];
    logic [1:0] b_dig [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_digits
            assign a_dig[gi] = a_reg[2*gi +: 2];
            assign b_dig[gi] = b_reg[2*gi +: 2];
        end
    endgenerate

    // Multiplier operands are only driven while calculating; zero otherwise.
    assign mul_a = (state_reg == CALC) ? a_dig[i_reg] : 2'b00;
    assign mul_b = (state_reg == CALC) ? b_dig[j_reg] : 2'b00;

    // Partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j).
    logic [IW:0]          dsum;
    logic [IW+1:0]        shamt;
    logic [2*WIDTH-1:0]   term;
    logic [2*WIDTH-1:0]   acc_next;

    assign dsum     = {1'b0, i_reg} + {1'b0, j_reg};
    assign shamt    = {dsum, 1'b0};
    assign term     = (2*WIDTH)'(mul_p) << shamt;
    assign acc_next = acc_reg + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            i_reg       <= '0;
            j_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        acc_reg   <= '0;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    if (i_reg == LAST && j_reg == LAST) begin
                        // Final digit pair: publish the sum directly.
                        product_reg <= acc_next;
                        acc_reg     <= '0;
                        i_reg       <= '0;
                        j_reg       <= '0;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        acc_reg <= acc_next;
                        if (j_reg == LAST) begin
                            j_reg <= '0;
                            i_reg <= i_reg + 1'b1;
                        end else begin
                            j_reg <= j_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_mult2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mult2_seq_ctrl: three instances (WIDTH = 8, 2, 4), each wired
// to its own behavioural 2x2 multiplier. The WIDTH=8 instance runs a table of
// operations plus a mid-operation reset; WIDTH=2 is swept exhaustively with
// back-to-back starts; WIDTH=4 runs random operands against a*b.
// ---------------------------------------------------------------------------
module tb_mult2_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 8
    logic        start8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [1:0]  mul_a8, mul_b8;
    logic [3:0]  mul_p8;
    logic        busy8, done8;
    logic [15:0] prod8;
    assign mul_p8 = {2'b00, mul_a8} * {2'b00, mul_b8};

    // WIDTH = 2
    logic        start2 = 0;
    logic [1:0]  a2 = 0, b2 = 0;
    logic [1:0]  mul_a2, mul_b2;
    logic [3:0]  mul_p2;
    logic        busy2, done2;
    logic [3:0]  prod2;
    assign mul_p2 = {2'b00, mul_a2} * {2'b00, mul_b2};

    // WIDTH = 4
    logic        start4 = 0;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [1:0]  mul_a4, mul_b4;
    logic [3:0]  mul_p4;
    logic        busy4, done4;
    logic [7:0]  prod4;
    assign mul_p4 = {2'b00, mul_a4} * {2'b00, mul_b4};

    mult2_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
        .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p8),
        .busy(busy8), .done(done8), .product(prod8));

    mult2_seq_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2),
        .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
        .busy(busy2), .done(done2), .product(prod2));

    mult2_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
        .mul_a(mul_a4), .mul_b(mul_b4), .mul_p(mul_p4),
        .busy(busy4), .done(done4), .product(prod4));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // WIDTH=4 monitor: count done pulses and busy/done overlap.
    int done4_count = 0;
    int overlap4 = 0;
    always @(negedge clk) begin
        if (rst_n && done4 === 1'b1) done4_count++;
        if (rst_n && done4 === 1'b1 && busy4 === 1'b1) overlap4++;
    end

    // Expected WIDTH=8 product register contents (changes only at completion).
    logic [15:0] prod_model8 = 16'h0;

    // One WIDTH=8 operation. Entered just after an edge with the DUT idle
    // (or in its done cycle); returns 1 ns after the completion edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input bit chaos);
        logic [15:0] old;
        int i, j;
        old = prod_model8;
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        chk("w8_accept_busy", busy8, 1);
        chk("w8_accept_done", done8, 0);
        if (!chaos) start8 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            i = k / 4;
            j = k % 4;
            if (chaos) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            chk("w8_mul_a", mul_a8, (a >> (2*i)) & 8'h3);
            chk("w8_mul_b", mul_b8, (b >> (2*j)) & 8'h3);
            chk("w8_hold", prod8, old);
            @(posedge clk); #1;
            if (k < 15) begin
                chk("w8_busy", busy8, 1);
                chk("w8_done_low", done8, 0);
            end else begin
                chk("w8_done", done8, 1);
                chk("w8_busy_end", busy8, 0);
                chk("w8_product", prod8, exp);
            end
        end
        prod_model8 = exp;
        $display("w8 op a=0x%02h b=0x%02h product=0x%04h", a, b, prod8);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        bit          chaos;
    } vec8_t;

    vec8_t vecs [5];

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0};
        vecs[1] = '{8'h5A, 8'h3C, 16'h1518, 1'b0};
        vecs[2] = '{8'h00, 8'hB7, 16'h0000, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 16'h03A8, 1'b1};  // start held, inputs churn
        vecs[4] = '{8'h21, 8'h43, 16'h08A3, 1'b0};  // accepted in done cycle

        // Reset state
        #12;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_product", prod8, 0);
        chk("rst_mul_a", mul_a8, 0);
        chk("rst_mul_b", mul_b8, 0);
        chk("rst_product2", prod2, 0);
        chk("rst_product4", prod4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++)
            op8(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].chaos);

        // Asynchronous reset in the middle of an operation
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_product", prod8, 0);
        chk("abort_mul_a", mul_a8, 0);
        chk("abort_mul_b", mul_b8, 0);
        $display("w8 reset mid-operation product=0x%04h", prod8);
        prod_model8 = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h03, 8'h05, 16'h000F, 1'b0);

        // WIDTH=2 exhaustive, back-to-back
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                a2 = 2'(a); b2 = 2'(b); start2 = 1'b1;
                @(posedge clk); #1;
                chk("w2_busy", busy2, 1);
                chk("w2_done_low", done2, 0);
                @(posedge clk); #1;
                chk("w2_done", done2, 1);
                chk("w2_busy_end", busy2, 0);
                chk("w2_product", prod2, a * b);
                $display("w2 op a=%0d b=%0d product=%0d", a, b, prod2);
            end
        end
        start2 = 1'b0;

        // WIDTH=4 random against a*b
        for (int n = 0; n < 100; n++) begin
            int c;
            int ea, eb;
            ea = int'($urandom_range(0, 15));
            eb = int'($urandom_range(0, 15));
            a4 = 4'(ea); b4 = 4'(eb); start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            c = 0;
            while (done4 !== 1'b1 && c < 10) begin
                @(posedge clk); #1;
                c++;
            end
            chk("w4_latency", c, 4);
            chk("w4_product", prod4, ea * eb);
            $display("w4 op a=%0d b=%0d product=%0d", ea, eb, prod4);
        end
        @(negedge clk); #1;
        chk("w4_done_count", done4_count, 100);
        chk("w4_busy_done_overlap", overlap4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
